// File: rtl/gb_irq_pkg.sv
// ============================================================================
// Module   : gb_irq_pkg
// Brief    : Shared defaults, source indices and FSM encoding for irq_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gb_irq_pkg;

  localparam logic [15:0] DEF_IF_ADDR       = 16'hFF0F;
  localparam logic [15:0] DEF_IE_ADDR       = 16'hFFFF;
  localparam logic [7:0]  DEF_VECTOR_BASE   = 8'h40;
  localparam logic [7:0]  DEF_VECTOR_STRIDE = 8'h08;
  localparam logic [7:0]  DEF_SPURIOUS_VEC  = 8'h00;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_LCDC   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam int             ST_W      = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_VECTOR = 2'd1;
  localparam logic [ST_W-1:0] ST_ACK    = 2'd2;

  // Index width that stays legal for a single-source build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
// Module   : irq_prio_enc
// Brief    : Combinational fixed-priority encoder, lowest set index wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module irq_prio_enc #(
  parameter int WIDTH = 5,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o
);

  always_comb begin
    valid_o = |req_i;
    index_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) index_o = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// ============================================================================
// Module   : irq_controller
// Brief    : IF/IE register file with edge/level capture and INTA vectoring FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module irq_controller
  import gb_irq_pkg::*;
#(
  parameter int                 NUM_IRQ       = 5,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK     = {NUM_IRQ{1'b1}},
  parameter logic [15:0]        IF_ADDR       = DEF_IF_ADDR,
  parameter logic [15:0]        IE_ADDR       = DEF_IE_ADDR,
  parameter logic [7:0]         VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter logic [7:0]         VECTOR_STRIDE = DEF_VECTOR_STRIDE,
  parameter logic [7:0]         SPURIOUS_VEC  = DEF_SPURIOUS_VEC
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cs,
  input  logic [15:0]        A,
  input  logic [7:0]         Di,
  output logic [7:0]         Do,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic               m1_n,
  input  logic               iorq_n,
  input  logic [NUM_IRQ-1:0] int_req,
  output logic [NUM_IRQ-1:0] int_ack,
  output logic               int_n,
  output logic [7:0]         jump_addr
);

  localparam int IDX_W = idx_width(NUM_IRQ);

  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic [NUM_IRQ-1:0] req_prev_q;
  logic               int_n_q;
  logic [ST_W-1:0]    state_q, state_d;
  logic [7:0]         jump_q, jump_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               valid_q, valid_d;

  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_ack_vec;
  logic               w_ack_fire;
  logic               w_inta;
  logic               w_wr_if;
  logic               w_wr_ie;
  logic               w_enc_valid;
  logic [IDX_W-1:0]   w_enc_idx;

  assign w_inta    = ~m1_n & ~iorq_n;
  assign w_wr_if   = cs & ~wr_n & (A == IF_ADDR);
  assign w_wr_ie   = cs & ~wr_n & (A == IE_ADDR);
  assign w_set     = (int_req & ~req_prev_q & EDGE_MASK) | (int_req & ~EDGE_MASK);
  assign w_pending = if_q & ie_q[NUM_IRQ-1:0];

  irq_prio_enc #(
    .WIDTH (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req_i   (w_pending),
    .valid_o (w_enc_valid),
    .index_o (w_enc_idx)
  );

  // Later assignments win: hardware set overrides ack clear overrides CPU write.
  always_comb begin
    if_d = if_q;
    if (w_wr_if) if_d = Di[NUM_IRQ-1:0];
    if_d = if_d & ~w_ack_vec;
    if_d = if_d | w_set;
  end

  always_comb begin
    ie_d = ie_q;
    if (w_wr_ie) ie_d = Di;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_q       <= '0;
      ie_q       <= '0;
      req_prev_q <= '0;
      int_n_q    <= 1'b1;
    end else begin
      if_q       <= if_d;
      ie_q       <= ie_d;
      req_prev_q <= int_req;
      int_n_q    <= ~|w_pending;
    end
  end

  always_comb begin
    Do = 8'hFF;
    if (cs && !rd_n) begin
      if (A == IF_ADDR)      Do[NUM_IRQ-1:0] = if_q;
      else if (A == IE_ADDR) Do              = ie_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_inta)  state_d = ST_VECTOR;
      ST_VECTOR: if (!w_inta) state_d = ST_ACK;
      ST_ACK:                 state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ack_fire = (state_q == ST_ACK) && valid_q;
    w_ack_vec  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_ack_vec[i] = w_ack_fire && (win_q == IDX_W'(i));
    end
  end

  // The vector is captured only on INTA entry so it stays stable for the whole cycle.
  always_comb begin
    jump_d  = jump_q;
    win_d   = win_q;
    valid_d = valid_q;
    if (state_q == ST_IDLE && w_inta) begin
      win_d   = w_enc_idx;
      valid_d = w_enc_valid;
      jump_d  = w_enc_valid ? VECTOR_BASE + 8'(w_enc_idx) * VECTOR_STRIDE : SPURIOUS_VEC;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jump_q  <= SPURIOUS_VEC;
      win_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      jump_q  <= jump_d;
      win_q   <= win_d;
      valid_q <= valid_d;
    end
  end

  assign int_ack   = w_ack_vec;
  assign int_n     = int_n_q;
  assign jump_addr = jump_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// ============================================================================
// Module   : tb_irq_controller
// Brief    : Self-checking bench for irq_controller with a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_irq_controller;

  localparam logic [4:0] EDGE = 5'b11110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0] di = 8'h00;
  logic [7:0] do_w;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       m1_n = 1'b1;
  logic       iorq_n = 1'b1;
  logic [4:0] int_req = 5'b00000;
  logic [4:0] int_ack;
  logic       int_n;
  logic [7:0] jump_addr;

  int n_checks = 0;
  int n_pass   = 0;

  irq_controller #(
    .NUM_IRQ   (5),
    .EDGE_MASK (EDGE)
  ) dut (
    .clock     (clk),
    .reset     (rst),
    .cs        (cs),
    .A         (a),
    .Di        (di),
    .Do        (do_w),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .m1_n      (m1_n),
    .iorq_n    (iorq_n),
    .int_req   (int_req),
    .int_ack   (int_ack),
    .int_n     (int_n),
    .jump_addr (jump_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: flag/enable bytes plus a record of the current INTA transaction.
  logic [4:0] m_if, m_prev, m_set, m_nif, m_pend;
  logic [7:0] m_ie, m_jump;
  logic       m_int_n, m_busy, m_ack_slot;
  int         m_win;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_if = '0; m_ie = '0; m_prev = '0; m_jump = 8'h00;
      m_int_n = 1'b1; m_busy = 1'b0; m_ack_slot = 1'b0; m_win = -1;
    end else begin
      for (int i = 0; i < 5; i++)
        m_set[i] = EDGE[i] ? (int_req[i] & ~m_prev[i]) : int_req[i];
      m_pend = m_if & m_ie[4:0];
      m_nif  = m_if;
      if (cs && !wr_n && a == 16'hFF0F) m_nif = di[4:0];
      if (m_ack_slot && m_win >= 0) m_nif[m_win] = 1'b0;
      m_nif = m_nif | m_set;
      if (cs && !wr_n && a == 16'hFFFF) m_ie = di;
      m_int_n = (m_pend == 5'b0);
      if (m_ack_slot) begin
        m_ack_slot = 1'b0;
      end else if (!m_busy && !m1_n && !iorq_n) begin
        m_busy = 1'b1;
        m_win  = -1;
        for (int i = 4; i >= 0; i--) if (m_pend[i]) m_win = i;
        m_jump = (m_win >= 0) ? 8'(64 + 8 * m_win) : 8'h00;
      end else if (m_busy && (m1_n || iorq_n)) begin
        m_busy     = 1'b0;
        m_ack_slot = 1'b1;
      end
      m_if   = m_nif;
      m_prev = int_req;
    end
  end

  function automatic logic [7:0] exp_ack();
    if (m_ack_slot && m_win >= 0) return 8'(1 << m_win);
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_do();
    if (!cs || rd_n)       return 8'hFF;
    if (a == 16'hFF0F)     return {3'b111, m_if};
    if (a == 16'hFFFF)     return m_ie;
    return 8'hFF;
  endfunction

  always @(negedge clk) begin
    chk("m_int_n",   {7'b0, int_n},   {7'b0, m_int_n});
    chk("m_int_ack", {3'b0, int_ack}, exp_ack());
    chk("m_jump",    jump_addr,       m_jump);
    chk("m_do",      do_w,            exp_do());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [7:0] exp, input string name);
    a = addr; cs = 1'b1; rd_n = 1'b0;
    #1;
    chk(name, do_w, exp);
    cs = 1'b0; rd_n = 1'b1; a = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    a = addr; di = data; cs = 1'b1; wr_n = 1'b0;
    tick();
    cs = 1'b0; wr_n = 1'b1; a = 16'h0000; di = 8'h00;
  endtask

  task automatic wait_int(input logic lvl, input string name);
    int k = 0;
    while (int_n !== lvl && k < 8) begin
      tick();
      k++;
    end
    chk(name, {7'b0, int_n}, {7'b0, lvl});
  endtask

  task automatic inta(input int n, input logic [7:0] exp, input string name);
    m1_n = 1'b0; iorq_n = 1'b0;
    repeat (n) begin
      tick();
      chk(name, jump_addr, exp);
    end
    m1_n = 1'b1; iorq_n = 1'b1;
  endtask

  task automatic pulse(input logic [4:0] v);
    int_req = v;
    tick();
    int_req = 5'b00000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every source requesting.
    int_req = 5'b11111;
    rst = 1'b1;
    tick(); tick();
    rd(16'hFF0F, 8'hE0, "rst_if");
    rd(16'hFFFF, 8'h00, "rst_ie");
    chk("rst_int_n", {7'b0, int_n}, 8'h01);
    chk("rst_ack",   {3'b0, int_ack}, 8'h00);
    chk("rst_jump",  jump_addr, 8'h00);
    int_req = 5'b00000;
    tick();
    rst = 1'b0;
    tick();

    // Single timer edge.
    wr(16'hFFFF, 8'h05);
    pulse(5'b00100);
    rd(16'hFF0F, 8'hE4, "t2_if");
    chk("t2_int_n_hi", {7'b0, int_n}, 8'h01);
    tick();
    chk("t2_int_n_lo", {7'b0, int_n}, 8'h00);
    inta(3, 8'h50, "t2_jump");
    tick();
    chk("t2_ack", {3'b0, int_ack}, 8'h04);
    tick();
    chk("t2_ack_off", {3'b0, int_ack}, 8'h00);
    rd(16'hFF0F, 8'hE0, "t2_if_clr");
    wait_int(1'b1, "t2_int_n_rel");

    // Two simultaneous sources are served in priority order.
    wr(16'hFFFF, 8'h1F);
    pulse(5'b10010);
    wait_int(1'b0, "t3_int_n");
    inta(2, 8'h48, "t3_jump1");
    tick();
    chk("t3_ack1", {3'b0, int_ack}, 8'h02);
    tick();
    chk("t3_int_n_hold", {7'b0, int_n}, 8'h00);
    rd(16'hFF0F, 8'hF0, "t3_if_mid");
    inta(2, 8'h60, "t3_jump2");
    tick();
    chk("t3_ack2", {3'b0, int_ack}, 8'h10);
    wait_int(1'b1, "t3_int_n_rel");
    rd(16'hFF0F, 8'hE0, "t3_if_end");

    // Enable withdrawn before INTA gives the spurious vector.
    pulse(5'b01000);
    wait_int(1'b0, "t4_int_n");
    wr(16'hFFFF, 8'h00);
    inta(2, 8'h00, "t4_jump");
    tick();
    chk("t4_ack_a", {3'b0, int_ack}, 8'h00);
    tick();
    chk("t4_ack_b", {3'b0, int_ack}, 8'h00);
    rd(16'hFF0F, 8'hE8, "t4_if");
    wr(16'hFF0F, 8'h00);

    // Level source held through ACK, then a write racing a set.
    wr(16'hFFFF, 8'h01);
    int_req = 5'b00001;
    wait_int(1'b0, "t5_int_n");
    inta(2, 8'h40, "t5_jump");
    tick();
    chk("t5_ack", {3'b0, int_ack}, 8'h01);
    tick();
    rd(16'hFF0F, 8'hE1, "t5_if_level");
    int_req = 5'b00000;
    tick();
    a = 16'hFF0F; di = 8'h00; cs = 1'b1; wr_n = 1'b0; int_req = 5'b01000;
    tick();
    cs = 1'b0; wr_n = 1'b1; a = 16'h0000; int_req = 5'b00000;
    rd(16'hFF0F, 8'hE8, "t5_if_race");
    wr(16'hFF0F, 8'h00);

    // Reset mid-VECTOR, then a fresh request.
    wr(16'hFFFF, 8'h1F);
    pulse(5'b00100);
    wait_int(1'b0, "t6_int_n");
    m1_n = 1'b0; iorq_n = 1'b0;
    tick();
    chk("t6_jump_pre", jump_addr, 8'h50);
    rst = 1'b1;
    #1;
    chk("t6_ack_rst",  {3'b0, int_ack}, 8'h00);
    chk("t6_int_n_rst", {7'b0, int_n}, 8'h01);
    chk("t6_jump_rst", jump_addr, 8'h00);
    rd(16'hFF0F, 8'hE0, "t6_if_rst");
    m1_n = 1'b1; iorq_n = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("t6_ack_post", {3'b0, int_ack}, 8'h00);
    wr(16'hFFFF, 8'h04);
    pulse(5'b00100);
    wait_int(1'b0, "t6_int_n2");
    inta(2, 8'h50, "t6_jump2");
    tick();
    chk("t6_ack2", {3'b0, int_ack}, 8'h04);
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Parametrised successor to the Game Boy interrupt controller. It supports N request sources, a per-source edge/level mode, IF/IE register files at parametrised addresses, and a fixed-priority vectoring FSM driven by the CPU's INTA cycle (m1_n and iorq_n both low). It sits between the peripherals (ppu, timer, joypad, serial) and the tv80s core, and supplies int_n and the jump_addr byte muxed onto Di_cpu during INTA.

Parameters:
NUM_IRQ, 5, number of sources (1..8); bit 0 has the highest priority.
EDGE_MASK, 5'b11111, per-source mode: 1 = rising-edge triggered, 0 = level triggered.
IF_ADDR, 16'hFF0F, address of the interrupt flag register.
IE_ADDR, 16'hFFFF, address of the interrupt enable register.
VECTOR_BASE, 8'h40, vector of source 0.
VECTOR_STRIDE, 8'h08, vector spacing between sources.
SPURIOUS_VEC, 8'h00, vector returned when nothing is pending at INTA.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cs  in  1  chip select from the MMU
A  in  16  CPU address
Di  in  8  write data from the CPU
Do  out  8  read data to the MMU
rd_n  in  1  read strobe, active low
wr_n  in  1  write strobe, active low
m1_n  in  1  CPU M1, active low
iorq_n  in  1  CPU IORQ, active low
int_req  in  NUM_IRQ  peripheral requests
int_ack  out  NUM_IRQ  one-cycle acknowledge pulse per source
int_n  out  1  interrupt line to the CPU, active low
jump_addr  out  8  vector byte presented during INTA

Behaviour:
- Reset (async, active-high) clears all state immediately:
  - IF=0, IE=0, req_d=0, FSM=IDLE.
  - Outputs: int_n=1, int_ack=0, jump_addr=SPURIOUS_VEC.
- Request capture, every clock:
  - set[i] = EDGE_MASK[i] ? (int_req[i] & ~req_d[i]) : int_req[i].
  - req_d <= int_req.
- IF bit update precedence, per bit: hardware set > ack clear > CPU write.
  - A CPU write of 0 on the same cycle as a set leaves the bit at 1.
- CPU writes (cs & ~wr_n, sampled on the clock edge):
  - A==IF_ADDR: IF <= Di[NUM_IRQ-1:0].
  - A==IE_ADDR: IE <= Di, all 8 bits stored.
  - A level-held write updates the register every cycle it is held.
- CPU reads (combinational, cs & ~rd_n):
  - IF_ADDR returns {unimplemented bits = 1, IF}.
  - IE_ADDR returns IE.
  - Any other address returns 8'hFF.
  - Do = 8'hFF when not selected.
- pending = IF & IE[NUM_IRQ-1:0]. int_n is registered: int_n <= ~|pending, so it reaches 0 one clock after pending becomes non-zero.
- INTA = ~m1_n & ~iorq_n.
- FSM states: IDLE, VECTOR, ACK.
  - IDLE -> VECTOR on the first INTA cycle:
    - The priority encoder picks the lowest set index k of pending.
    - jump_addr <= VECTOR_BASE + k*VECTOR_STRIDE (8-bit, wraps mod 256); latch win=k, valid=1.
    - If pending==0: jump_addr <= SPURIOUS_VEC, valid=0.
  - VECTOR: jump_addr is held stable while INTA stays asserted, even if IF/IE change. Leaves to ACK when INTA deasserts.
  - ACK, a single cycle:
    - If valid: clear IF[win] and pulse int_ack[win]=1 for exactly one clock.
    - Return to IDLE; int_n re-evaluates from the updated pending on the next cycle.
- A new request arriving during VECTOR/ACK sets IF normally. If it targets win, the set beats the ack clear and the bit stays 1.
- Reset asserted in VECTOR/ACK aborts to IDLE: no int_ack pulse, IF cleared.
- NUM_IRQ<8: IE upper bits are storage only and never contribute to pending.

Decomposition:
- Shared package gb_irq_pkg holds:
  - default addresses (IF_ADDR, IE_ADDR);
  - VECTOR_BASE, VECTOR_STRIDE, SPURIOUS_VEC;
  - source indices IRQ_VBLANK=0, IRQ_LCDC=1, IRQ_TIMER=2, IRQ_SERIAL=3, IRQ_JOYPAD=4;
  - the FSM state encoding.
- Sub-module irq_prio_enc, parametrised by width, is combinational lowest-index-first and outputs {valid, index}. It is instantiated once.

Test Plan:
- Reset while int_req=5'b11111 -> IF reads 8'hE0, IE=0, int_n=1, int_ack=0, jump_addr=8'h00.
- IE=8'h05, rising edge on int_req[2] -> IF=8'hE4, int_n=0 one clock later. INTA -> jump_addr=8'h50 held through INTA. INTA end -> int_ack=5'b00100 for one clock, IF=8'hE0, int_n=1.
- IE=8'h1F, set sources 4 and 1 in the same cycle -> first INTA returns 8'h48 and acks bit 1. int_n stays 0. Second INTA returns 8'h60 and acks bit 4.
- Write IE=0 between int_n low and INTA -> jump_addr=8'h00, no int_ack pulse, IF bit remains set.
- Level source (EDGE_MASK[0]=0) held high through ACK -> IF[0] stays 1 after the ack pulse. Same-cycle CPU write IF=0 with a source-3 edge -> IF reads 8'hE8.
- Reset asserted mid-VECTOR -> FSM returns to IDLE, no int_ack, IF=0; after release, a fresh request vectors normally.
